// File: rtl/tri_raster_stream.sv
// tri_raster_stream
//   Screen-space triangle rasterizer. Collects three vertices over a
//   valid/ready stream, sets up three edge functions, clamps the bounding
//   box to the screen and scans it row-major. Edge values, pixel position
//   and framebuffer address are all updated incrementally during the scan.
//   Every covered pixel becomes one fragment on a backpressured stream.
//
//   Optional feature: define CULL_BACKFACE_EN to drop negative-area
//   (clockwise) triangles. Without it, clockwise triangles have their edge
//   equations negated and rasterize like their counter-clockwise twins.
//
// Ports
//   I_CLOCK, I_RESET_N          clock, async active-low reset
//   I_VTX_VALID/O_VTX_READY     vertex handshake; ready only while idle
//   I_VTX_X/Y/COLOR             signed vertex position, vertex colour
//   O_FRAG_VALID/I_FRAG_READY   fragment handshake
//   O_FRAG_X/Y/ADDR/COLOR       fragment position, y*SCREEN_W+x, flat colour
//   O_BUSY                      triangle in progress
//   O_DONE                      one-cycle pulse when a triangle completes
module tri_raster_stream #(
   parameter int COORD_W   = 12,
   parameter int COLOR_W   = 16,
   parameter int SCREEN_W  = 640,
   parameter int SCREEN_H  = 400,
   parameter int ADDR_W    = 18,
   parameter int PROVOKING = 0,
   localparam int XW = $clog2(SCREEN_W),
   localparam int YW = $clog2(SCREEN_H)
) (
   input  logic                      I_CLOCK,
   input  logic                      I_RESET_N,
   input  logic                      I_VTX_VALID,
   output logic                      O_VTX_READY,
   input  logic signed [COORD_W-1:0] I_VTX_X,
   input  logic signed [COORD_W-1:0] I_VTX_Y,
   input  logic [COLOR_W-1:0]        I_VTX_COLOR,
   output logic                      O_FRAG_VALID,
   input  logic                      I_FRAG_READY,
   output logic [XW-1:0]             O_FRAG_X,
   output logic [YW-1:0]             O_FRAG_Y,
   output logic [ADDR_W-1:0]         O_FRAG_ADDR,
   output logic [COLOR_W-1:0]        O_FRAG_COLOR,
   output logic                      O_BUSY,
   output logic                      O_DONE
);

   localparam int EDGE_W = 2*COORD_W + 2;
   localparam logic [ADDR_W-1:0] SW_A = ADDR_W'(SCREEN_W);

   typedef enum logic [2:0] {
      S_IDLE, S_SETUP, S_BBOX, S_INIT, S_SCAN, S_DRAIN, S_FINISH
   } state_t;

   state_t                     state;
   logic [1:0]                 vcnt;
   logic signed [COORD_W-1:0]  vx [3];
   logic signed [COORD_W-1:0]  vy [3];
   logic [COLOR_W-1:0]         color;
   logic signed [EDGE_W-1:0]   ea [3];
   logic signed [EDGE_W-1:0]   eb [3];
   logic signed [EDGE_W-1:0]   ec [3];
   logic signed [EDGE_W-1:0]   e [3];
   logic signed [EDGE_W-1:0]   erow [3];
   logic signed [EDGE_W-1:0]   area;
   logic [XW-1:0]              minx, maxx, x;
   logic [YW-1:0]              miny, maxy, y;
   logic [ADDR_W-1:0]          addr, row_addr;

   logic                       frag_valid;
   logic [XW-1:0]              frag_x;
   logic [YW-1:0]              frag_y;
   logic [ADDR_W-1:0]          frag_addr;
   logic [COLOR_W-1:0]         frag_color;

   // raw (unclamped) bounding box, widened so screen limits compare safely
   logic signed [31:0]         lo_x, hi_x, lo_y, hi_y;
   logic                       bb_empty;
   logic signed [EDGE_W-1:0]   minx_s, miny_s;
   logic signed [EDGE_W-1:0]   e_init [3];
   logic                       covered;

   always_comb begin
      lo_x = 32'(vx[0]);
      hi_x = lo_x;
      lo_y = 32'(vy[0]);
      hi_y = lo_y;
      for (int i = 1; i < 3; i++) begin
         if (32'(vx[i]) < lo_x) lo_x = 32'(vx[i]);
         if (32'(vx[i]) > hi_x) hi_x = 32'(vx[i]);
         if (32'(vy[i]) < lo_y) lo_y = 32'(vy[i]);
         if (32'(vy[i]) > hi_y) hi_y = 32'(vy[i]);
      end
      // empty must be judged before clamping, otherwise a fully offscreen
      // triangle would collapse onto the screen border
      bb_empty = (hi_x < 0) || (lo_x > SCREEN_W-1) ||
                 (hi_y < 0) || (lo_y > SCREEN_H-1);
   end

   assign minx_s = EDGE_W'(minx);
   assign miny_s = EDGE_W'(miny);

   always_comb begin
      for (int k = 0; k < 3; k++)
         e_init[k] = ea[k]*minx_s + eb[k]*miny_s + ec[k];
   end

   // inclusive coverage: every edge value non-negative
   assign covered = ~e[0][EDGE_W-1] & ~e[1][EDGE_W-1] & ~e[2][EDGE_W-1];

   always_ff @(posedge I_CLOCK or negedge I_RESET_N) begin
      if (!I_RESET_N) begin
         state      <= S_IDLE;
         vcnt       <= '0;
         color      <= '0;
         area       <= '0;
         minx       <= '0;
         maxx       <= '0;
         miny       <= '0;
         maxy       <= '0;
         x          <= '0;
         y          <= '0;
         addr       <= '0;
         row_addr   <= '0;
         frag_valid <= 1'b0;
         frag_x     <= '0;
         frag_y     <= '0;
         frag_addr  <= '0;
         frag_color <= '0;
         for (int k = 0; k < 3; k++) begin
            vx[k] <= '0;  vy[k] <= '0;
            ea[k] <= '0;  eb[k] <= '0;  ec[k] <= '0;
            e[k]  <= '0;  erow[k] <= '0;
         end
      end else begin
         case (state)
            S_IDLE: if (I_VTX_VALID) begin
               for (int k = 0; k < 3; k++)
                  if (vcnt == 2'(k)) begin
                     vx[k] <= I_VTX_X;
                     vy[k] <= I_VTX_Y;
                  end
               if (vcnt == 2'(PROVOKING)) color <= I_VTX_COLOR;
               if (vcnt == 2'd2) begin
                  vcnt  <= '0;
                  state <= S_SETUP;
               end else begin
                  vcnt <= vcnt + 2'd1;
               end
            end
            S_SETUP: begin
               // edge k runs from vertex k+1 to vertex k+2
               for (int k = 0; k < 3; k++) begin
                  ea[k] <= EDGE_W'(vy[(k+1)%3]) - EDGE_W'(vy[(k+2)%3]);
                  eb[k] <= EDGE_W'(vx[(k+2)%3]) - EDGE_W'(vx[(k+1)%3]);
                  ec[k] <= EDGE_W'(vx[(k+1)%3]) * EDGE_W'(vy[(k+2)%3]) -
                           EDGE_W'(vx[(k+2)%3]) * EDGE_W'(vy[(k+1)%3]);
               end
               area <= (EDGE_W'(vx[1]) - EDGE_W'(vx[0])) * (EDGE_W'(vy[2]) - EDGE_W'(vy[0])) -
                       (EDGE_W'(vx[2]) - EDGE_W'(vx[0])) * (EDGE_W'(vy[1]) - EDGE_W'(vy[0]));
               state <= S_BBOX;
            end
            S_BBOX: begin
               minx <= XW'(lo_x < 0 ? 0 : lo_x);
               maxx <= XW'(hi_x > SCREEN_W-1 ? SCREEN_W-1 : hi_x);
               miny <= YW'(lo_y < 0 ? 0 : lo_y);
               maxy <= YW'(hi_y > SCREEN_H-1 ? SCREEN_H-1 : hi_y);
               if (bb_empty || area == '0) begin
                  state <= S_FINISH;
               end else if (area < 0) begin
`ifdef CULL_BACKFACE_EN
                  state <= S_FINISH;
`else
                  // flip winding so coverage tests stay "all >= 0"
                  for (int k = 0; k < 3; k++) begin
                     ea[k] <= -ea[k];
                     eb[k] <= -eb[k];
                     ec[k] <= -ec[k];
                  end
                  state <= S_INIT;
`endif
               end else begin
                  state <= S_INIT;
               end
            end
            S_INIT: begin
               for (int k = 0; k < 3; k++) begin
                  e[k]    <= e_init[k];
                  erow[k] <= e_init[k];
               end
               x        <= minx;
               y        <= miny;
               addr     <= ADDR_W'(miny) * SW_A + ADDR_W'(minx);
               row_addr <= ADDR_W'(miny) * SW_A + ADDR_W'(minx);
               state    <= S_SCAN;
            end
            S_SCAN: if (!frag_valid || I_FRAG_READY) begin
               frag_valid <= covered;
               if (covered) begin
                  frag_x     <= x;
                  frag_y     <= y;
                  frag_addr  <= addr;
                  frag_color <= color;
               end
               if (x == maxx) begin
                  if (y == maxy) begin
                     state <= S_DRAIN;
                  end else begin
                     x        <= minx;
                     y        <= y + 1'b1;
                     addr     <= row_addr + SW_A;
                     row_addr <= row_addr + SW_A;
                     for (int k = 0; k < 3; k++) begin
                        erow[k] <= erow[k] + eb[k];
                        e[k]    <= erow[k] + eb[k];
                     end
                  end
               end else begin
                  x    <= x + 1'b1;
                  addr <= addr + 1'b1;
                  for (int k = 0; k < 3; k++) e[k] <= e[k] + ea[k];
               end
            end
            // wait for the final fragment, if any, to be taken
            S_DRAIN: if (!frag_valid || I_FRAG_READY) begin
               frag_valid <= 1'b0;
               state      <= S_FINISH;
            end
            S_FINISH: state <= S_IDLE;
            default:  state <= S_IDLE;
         endcase
      end
   end

   assign O_VTX_READY  = (state == S_IDLE);
   assign O_BUSY       = (state != S_IDLE);
   assign O_DONE       = (state == S_FINISH);
   assign O_FRAG_VALID = frag_valid;
   assign O_FRAG_X     = frag_x;
   assign O_FRAG_Y     = frag_y;
   assign O_FRAG_ADDR  = frag_addr;
   assign O_FRAG_COLOR = frag_color;

endmodule

// File: tb/tb_tri_raster_stream.sv
// Directed bench for tri_raster_stream: a 640x400 instance (a) and a
// 16x8 instance (b). Expected fragments come from hand-derived half-plane
// regions pushed into per-instance queues, checked in scan order.
module tb_tri_raster_stream;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic                     rst_n;
   logic [1:0]               vv, fr;
   logic signed [11:0]       vx [2];
   logic signed [11:0]       vy [2];
   logic [15:0]              vc [2];

   logic a_vrdy, a_fv, a_busy, a_done;
   logic [9:0]  a_fx;
   logic [8:0]  a_fy;
   logic [17:0] a_fa;
   logic [15:0] a_fc;

   logic b_vrdy, b_fv, b_busy, b_done;
   logic [3:0]  b_fx;
   logic [2:0]  b_fy;
   logic [17:0] b_fa;
   logic [15:0] b_fc;

   logic [1:0] vrdy, dn;
   assign vrdy = {b_vrdy, a_vrdy};
   assign dn   = {b_done, a_done};

   tri_raster_stream dut_a (
      .I_CLOCK(clk), .I_RESET_N(rst_n),
      .I_VTX_VALID(vv[0]), .O_VTX_READY(a_vrdy),
      .I_VTX_X(vx[0]), .I_VTX_Y(vy[0]), .I_VTX_COLOR(vc[0]),
      .O_FRAG_VALID(a_fv), .I_FRAG_READY(fr[0]),
      .O_FRAG_X(a_fx), .O_FRAG_Y(a_fy), .O_FRAG_ADDR(a_fa), .O_FRAG_COLOR(a_fc),
      .O_BUSY(a_busy), .O_DONE(a_done));

   tri_raster_stream #(.SCREEN_W(16), .SCREEN_H(8)) dut_b (
      .I_CLOCK(clk), .I_RESET_N(rst_n),
      .I_VTX_VALID(vv[1]), .O_VTX_READY(b_vrdy),
      .I_VTX_X(vx[1]), .I_VTX_Y(vy[1]), .I_VTX_COLOR(vc[1]),
      .O_FRAG_VALID(b_fv), .I_FRAG_READY(fr[1]),
      .O_FRAG_X(b_fx), .O_FRAG_Y(b_fy), .O_FRAG_ADDR(b_fa), .O_FRAG_COLOR(b_fc),
      .O_BUSY(b_busy), .O_DONE(b_done));

   typedef struct {int x; int y; int addr;} frag_t;
   frag_t qa[$], qb[$];
   frag_t fa_h, fb_h;
   int n_chk = 0, n_fail = 0;
   int cnt [2];
   int dones [2];
   int exp_col [2];

   task automatic chk(input string tag, input int got, input int exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   // handshakes complete at the next rising edge; inputs only move at posedge+1
   always @(negedge clk) begin
      if (a_done) dones[0]++;
      if (b_done) dones[1]++;
      if (a_fv && fr[0]) begin
         cnt[0]++;
         if (qa.size() != 0) begin
            fa_h = qa.pop_front();
            chk("a_x", int'(a_fx), fa_h.x);
            chk("a_y", int'(a_fy), fa_h.y);
            chk("a_addr", int'(a_fa), fa_h.addr);
            chk("a_color", int'(a_fc), exp_col[0]);
         end
      end
      if (b_fv && fr[1]) begin
         cnt[1]++;
         if (qb.size() != 0) begin
            fb_h = qb.pop_front();
            chk("b_x", int'(b_fx), fb_h.x);
            chk("b_y", int'(b_fy), fb_h.y);
            chk("b_addr", int'(b_fa), fb_h.addr);
            chk("b_color", int'(b_fc), exp_col[1]);
         end
      end
   end

   // expected pixels: box [xa..xb]x[ya..yb] with (x-ox)+(y-oy) <= s
   task automatic fill(input int i, input int w, input int xa, input int xb,
                       input int ya, input int yb, input int ox, input int oy, input int s);
      frag_t f;
      for (int yy = ya; yy <= yb; yy++)
         for (int xx = xa; xx <= xb; xx++)
            if ((xx - ox) + (yy - oy) <= s) begin
               f.x = xx; f.y = yy; f.addr = yy*w + xx;
               if (i == 0) qa.push_back(f); else qb.push_back(f);
            end
      cnt[i] = 0;
      dones[i] = 0;
   endtask

   // returns at posedge+1 right after the handshake edge
   task automatic send_vtx(input int i, input int x, input int y, input int c);
      int n;
      vx[i] = 12'(x); vy[i] = 12'(y); vc[i] = 16'(c); vv[i] = 1'b1;
      n = 0;
      while (!vrdy[i] && n < 50) begin @(posedge clk); #1; n++; end
      if (n >= 50) chk("vtx_timeout", n, 0);
      @(posedge clk); #1;
      vv[i] = 1'b0;
   endtask

   task automatic send_tri(input int i, input int x0, input int y0, input int x1,
                           input int y1, input int x2, input int y2, input int c);
      exp_col[i] = c;
      send_vtx(i, x0, y0, c);
      send_vtx(i, x1, y1, c ^ 16'h0101);
      send_vtx(i, x2, y2, c ^ 16'h0202);
   endtask

   task automatic wait_done(input int i, input string tag);
      int n;
      n = 0;
      while (!dn[i] && n < 400) begin @(posedge clk); #1; n++; end
      chk(tag, int'(n < 400), 1);
      @(posedge clk); #1;
   endtask

   initial begin
      int n;
      rst_n = 1'b0; vv = '0; fr = 2'b11;
      for (int i = 0; i < 2; i++) begin
         vx[i] = '0; vy[i] = '0; vc[i] = '0; cnt[i] = 0; dones[i] = 0; exp_col[i] = 0;
      end
      repeat (2) @(posedge clk); #1;
      chk("rst_vrdy", int'(a_vrdy), 1);
      chk("rst_fv", int'(a_fv), 0);
      chk("rst_busy", int'(a_busy), 0);
      chk("rst_done", int'(a_done), 0);
      chk("rst_addr", int'(a_fa), 0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // 1: CCW right triangle, 15 fragments, latency to first fragment
      fill(0, 640, 0, 4, 0, 4, 0, 0, 4);
      send_tri(0, 0, 0, 4, 0, 0, 4, 16'h1234);
      chk("s1_busy", int'(a_busy), 1);
      chk("s1_vrdy", int'(a_vrdy), 0);
      repeat (3) begin @(posedge clk); #1; end
      chk("s1_fv_early", int'(a_fv), 0);
      @(posedge clk); #1;
      chk("s1_fv_first", int'(a_fv), 1);
      wait_done(0, "s1_done_seen");
      chk("s1_cnt", cnt[0], 15);
      chk("s1_left", qa.size(), 0);
      chk("s1_dones", dones[0], 1);
      chk("s1_idle_busy", int'(a_busy), 0);
      chk("s1_idle_vrdy", int'(a_vrdy), 1);

      // 2: clockwise winding, with a 5-cycle stall mid-scan
`ifdef CULL_BACKFACE_EN
      fill(0, 640, 0, 4, 0, 4, 0, 0, 4);
      qa.delete();
      send_tri(0, 0, 0, 0, 4, 4, 0, 16'h5678);
      wait_done(0, "s2_done_seen");
      chk("s2_cnt", cnt[0], 0);
      chk("s2_dones", dones[0], 1);
`else
      fill(0, 640, 0, 4, 0, 4, 0, 0, 4);
      send_tri(0, 0, 0, 0, 4, 4, 0, 16'h5678);
      n = 0;
      while (!(cnt[0] >= 5 && a_fv) && n < 200) begin @(posedge clk); #1; n++; end
      chk("s2_stall_reach", int'(n < 200), 1);
      fr[0] = 1'b0;
      repeat (5) begin
         @(posedge clk); #1;
         chk("s2_hold_v", int'(a_fv), 1);
         chk("s2_hold_x", int'(a_fx), qa[0].x);
         chk("s2_hold_y", int'(a_fy), qa[0].y);
         chk("s2_hold_addr", int'(a_fa), qa[0].addr);
         chk("s2_hold_col", int'(a_fc), 16'h5678);
      end
      fr[0] = 1'b1;
      wait_done(0, "s2_done_seen");
      chk("s2_cnt", cnt[0], 15);
      chk("s2_left", qa.size(), 0);
      chk("s2_dones", dones[0], 1);
`endif

      // 3: small screen, bbox clamped to 0..15 x 0..7
      fill(1, 16, 0, 15, 0, 7, 0, 0, 10);
      send_tri(1, -10, -10, 20, -10, -10, 20, 16'h0F0F);
      wait_done(1, "s3_done_seen");
      chk("s3_cnt", cnt[1], 60);
      chk("s3_left", qb.size(), 0);
      chk("s3_dones", dones[1], 1);

      // 4: collinear, exact FINISH timing, extra vertex refused while busy
      fill(0, 640, 0, -1, 0, -1, 0, 0, 0);
      send_tri(0, 0, 0, 2, 2, 4, 4, 16'hAAAA);
      vx[0] = 12'sd7; vy[0] = 12'sd7; vv[0] = 1'b1;
      chk("s4_t0_vrdy", int'(a_vrdy), 0);
      chk("s4_t0_done", int'(a_done), 0);
      @(posedge clk); #1;
      chk("s4_t1_vrdy", int'(a_vrdy), 0);
      chk("s4_t1_done", int'(a_done), 0);
      @(posedge clk); #1;
      chk("s4_t2_done", int'(a_done), 1);
      chk("s4_t2_busy", int'(a_busy), 1);
      chk("s4_t2_vrdy", int'(a_vrdy), 0);
      @(posedge clk); #1;
      vv[0] = 1'b0;
      chk("s4_t3_busy", int'(a_busy), 0);
      chk("s4_t3_done", int'(a_done), 0);
      chk("s4_cnt", cnt[0], 0);
      chk("s4_dones", dones[0], 1);

      // 5: reset mid-scan discards the triangle without DONE
      fill(0, 640, 0, 4, 0, 4, 0, 0, 4);
      send_tri(0, 0, 0, 4, 0, 0, 4, 16'h1234);
      n = 0;
      while (cnt[0] < 4 && n < 200) begin @(posedge clk); #1; n++; end
      chk("s5_reach", int'(n < 200), 1);
      #2 rst_n = 1'b0;
      #1;
      chk("s5_fv", int'(a_fv), 0);
      chk("s5_fx", int'(a_fx), 0);
      chk("s5_fy", int'(a_fy), 0);
      chk("s5_addr", int'(a_fa), 0);
      chk("s5_col", int'(a_fc), 0);
      chk("s5_busy", int'(a_busy), 0);
      chk("s5_done", int'(a_done), 0);
      chk("s5_vrdy", int'(a_vrdy), 1);
      @(posedge clk); #1;
      rst_n = 1'b1;
      qa.delete();
      repeat (4) begin @(posedge clk); #1; end
      chk("s5_no_done", dones[0], 0);

      // 6: fresh triangle after reset, offset from the origin
      fill(0, 640, 2, 6, 1, 5, 2, 1, 4);
      send_tri(0, 2, 1, 6, 1, 2, 5, 16'hBEEF);
      wait_done(0, "s6_done_seen");
      chk("s6_cnt", cnt[0], 15);
      chk("s6_left", qa.size(), 0);
      chk("s6_dones", dones[0], 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/tri_raster_stream.md
Name: tri_raster_stream

Overview:
- Parametrised screen-space triangle rasterizer, successor to the fixed 640x400 rasterizer.
- Accepts three vertices over a valid/ready stream and runs edge-function setup with an incrementally updated scan, with no per-pixel multipliers.
- Emits one covered fragment (x, y, linear framebuffer address, flat colour) per cycle over a backpressured valid/ready stream.
- Sits between the vertex/geometry stage and the framebuffer writer; O_BUSY replaces the old frame-stall output.

Parameters:
COORD_W, 12, signed vertex coordinate width (integer pixel units)
COLOR_W, 16, vertex/fragment colour width
SCREEN_W, 640, screen width in pixels
SCREEN_H, 400, screen height in pixels
ADDR_W, 18, framebuffer address width; must satisfy SCREEN_W*SCREEN_H <= 2^ADDR_W
PROVOKING, 0, vertex index (0..2) whose colour is used for every fragment

Ports:
I_CLOCK  in  1  clock, all state on rising edge
I_RESET_N  in  1  asynchronous active-low reset
I_VTX_VALID  in  1  vertex present
O_VTX_READY  out  1  vertex accepted when VALID&&READY
I_VTX_X  in  COORD_W  signed vertex x
I_VTX_Y  in  COORD_W  signed vertex y
I_VTX_COLOR  in  COLOR_W  vertex colour
O_FRAG_VALID  out  1  fragment present
I_FRAG_READY  in  1  consumer accepts fragment
O_FRAG_X  out  clog2(SCREEN_W)  fragment x
O_FRAG_Y  out  clog2(SCREEN_H)  fragment y
O_FRAG_ADDR  out  ADDR_W  y*SCREEN_W+x
O_FRAG_COLOR  out  COLOR_W  provoking-vertex colour
O_BUSY  out  1  high from third vertex accepted until triangle done
O_DONE  out  1  one-cycle pulse when a triangle finishes (including culled or empty)

Behaviour:
- Reset (async assert, sync release): state IDLE, vertex count 0; O_VTX_READY=1 only in IDLE. All other outputs 0. In-flight triangle is discarded, with no O_DONE.
- IDLE: latches vertices 0,1,2 in arrival order. On the third handshake, O_VTX_READY drops the same edge and the block enters SETUP.
- SETUP (1 cycle): for edge k from Va to Vb (k0: V1->V2, k1: V2->V0, k2: V0->V1), compute A=ya-yb, B=xb-xa, C=xa*yb-xb*ya.
- Edge widths: EDGE_W=2*COORD_W+2 signed. Twice-area = E0(V0).
- BBOX (1 cycle): min/max of x and y over the vertices, clamped to [0,SCREEN_W-1] and [0,SCREEN_H-1].
  - Empty box (minx>maxx or miny>maxy, fully offscreen) or area==0: go to FINISH.
  - Negative area: go to FINISH if CULL_BACKFACE_EN is defined; otherwise negate all A,B,C and continue.
- INIT (1 cycle): row values Ek=Ak*minx+Bk*miny+Ck; x=minx, y=miny.
- SCAN: a pixel is covered iff E0>=0 && E1>=0 && E2>=0. The rule is inclusive; there is no top-left rule.
  - Covered: O_FRAG_VALID=1 with registered x/y/addr/colour. Hold all fields stable until I_FRAG_READY, then advance.
  - Not covered: advance on the same cycle, no fragment.
  - Advance: x+1, Ek+=Ak. At x==maxx: x=minx, y+1, row Ek+=Bk, and Ek reloads from row.
  - After (maxx,maxy) is accepted or rejected: FINISH.
- Throughput and latency:
  - One pixel per cycle when not stalled.
  - First pixel evaluated 3 cycles after the third vertex handshake.
  - O_FRAG_VALID never deasserts without a handshake.
- FINISH (1 cycle): O_DONE=1, O_BUSY=0 next cycle, return to IDLE. A new vertex may be accepted the cycle after FINISH.
- O_FRAG_ADDR is computed incrementally (add 1 per x step, add SCREEN_W per row start); no multiplier.
- Scan order: row-major, y ascending, x ascending.

Optional Feature:
- CULL_BACKFACE_EN defined: negative-area (clockwise) triangles emit zero fragments; O_BUSY high for SETUP+BBOX+FINISH, then O_DONE pulses.
- Undefined: two-sided; clockwise triangles rasterize identically to their counter-clockwise equivalents.

Test Plan:
- V(0,0),(4,0),(0,4), colour 0x1234, READY=1 -> 15 fragments satisfying x+y<=4. First is (0,0) addr 0; last is (0,4) addr 2560; all colour 0x1234; one O_DONE.
- V(0,0),(0,4),(4,0) -> with CULL_BACKFACE_EN: 0 fragments, O_DONE after 3 cycles. Without: the same 15 fragments as the previous scenario.
- SCREEN_W=16, SCREEN_H=8, V(-10,-10),(20,-10),(-10,20) -> bbox clamped to 0..15 x 0..7. Exactly 60 fragments (x+y<=10), none outside the screen.
- Collinear V(0,0),(2,2),(4,4) -> 0 fragments, O_DONE pulse. Fourth vertex offered during O_BUSY sees O_VTX_READY=0.
- Backpressure: drop I_FRAG_READY for 5 cycles mid-scan -> O_FRAG_VALID stays 1 and X/Y/ADDR/COLOR stay stable. Total fragment count is unchanged.
- Assert I_RESET_N=0 mid-scan -> outputs 0 immediately, no O_DONE. The next triangle rasterizes correctly from IDLE.
